// File: rtl/ft_fifo_bus_ctrl.sv
// FT245-style synchronous FIFO bus sequencer: round-robin RX/TX ownership with a burst cap,
// OE/RD/WR sequencing and a turnaround cycle between directions.
module ft_fifo_bus_ctrl #(
  parameter int MAX_BURST = 512,
  parameter bit SEND_IMM  = 1'b1
) (
  input  logic        FT_CLK,
  input  logic        rst,
  input  logic        enable,
  input  logic        ft_rxf_n,
  input  logic        ft_txe_n,
  input  logic [7:0]  ft_data_i,
  output logic [7:0]  ft_data_o,
  output logic        ft_data_oe,
  output logic        ft_oe_n,
  output logic        ft_rd_n,
  output logic        ft_wr_n,
  output logic        ft_siwu_n,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_afull,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        busy,
  output logic [31:0] rx_cnt,
  output logic [31:0] tx_cnt
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RX_OE  = 3'd1;
  localparam logic [2:0] S_RX_RD  = 3'd2;
  localparam logic [2:0] S_RX_END = 3'd3;
  localparam logic [2:0] S_TX_WR  = 3'd4;
  localparam logic [2:0] S_TX_END = 3'd5;

  logic [2:0]    state, state_nxt;
  logic [BW-1:0] burst;
  logic [BW-1:0] burst_inc;
  logic          last_tx;
  logic          rx_req, tx_req, rd_now, tx_xfer, siwu_nxt;

  assign rx_req    = enable & ~ft_rxf_n & ~rx_afull;
  assign tx_req    = enable & ~ft_txe_n & tx_valid;
  assign rd_now    = (state == S_RX_RD) & ~ft_rxf_n;
  assign tx_xfer   = (state == S_TX_WR) & tx_valid & ~ft_txe_n;
  assign burst_inc = burst + 1'b1;

  assign ft_data_o = tx_data;
  assign ft_wr_n   = ~((state == S_TX_WR) & tx_valid);
  assign tx_ready  = tx_xfer;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    siwu_nxt  = 1'b1;
    case (state)
      S_IDLE: begin
        // On contention the direction not served last wins.
        if (rx_req && (!tx_req || last_tx)) state_nxt = S_RX_OE;
        else if (tx_req)                    state_nxt = S_TX_WR;
      end
      S_RX_OE: state_nxt = S_RX_RD;
      S_RX_RD: begin
        if (ft_rxf_n || rx_afull || !enable || (rd_now && burst_inc == BURST_MAX))
          state_nxt = S_RX_END;
      end
      S_RX_END: state_nxt = S_IDLE;
      S_TX_WR: begin
        if (ft_txe_n || !tx_valid || !enable || (tx_xfer && burst_inc == BURST_MAX)) begin
          state_nxt = S_TX_END;
          siwu_nxt  = ~(SEND_IMM & ~tx_valid);
        end
      end
      S_TX_END: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Pin strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge FT_CLK or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ft_oe_n    <= 1'b1;
      ft_rd_n    <= 1'b1;
      ft_data_oe <= 1'b0;
      ft_siwu_n  <= 1'b1;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      rx_cnt     <= 32'd0;
      tx_cnt     <= 32'd0;
      last_tx    <= 1'b1;
      burst      <= '0;
    end else begin
      state      <= state_nxt;
      ft_oe_n    <= ~((state_nxt == S_RX_OE) || (state_nxt == S_RX_RD));
      ft_rd_n    <= ~(state_nxt == S_RX_RD);
      ft_data_oe <= (state_nxt == S_TX_WR);
      ft_siwu_n  <= siwu_nxt;
      rx_valid   <= rd_now;
      if (rd_now) begin
        rx_data <= ft_data_i;
        rx_cnt  <= rx_cnt + 32'd1;
      end
      if (tx_xfer) tx_cnt <= tx_cnt + 32'd1;
      if (state == S_IDLE && state_nxt != S_IDLE) begin
        last_tx <= (state_nxt == S_TX_WR);
        burst   <= '0;
      end else if (rd_now || tx_xfer) begin
        burst <= burst_inc;
      end
    end
  end

endmodule

// File: tb/tb_ft_fifo_bus_ctrl.sv
// Bench for ft_fifo_bus_ctrl: FT chip + TX FIFO + RX sink modelled as byte queues,
// with a monitor logging bursts, gaps and pin invariants.
module tb_ft_fifo_bus_ctrl;
  localparam int MB = 6;

  logic        FT_CLK = 1'b0;
  logic        rst, enable, ft_rxf_n, ft_txe_n, rx_afull, tx_valid;
  logic [7:0]  ft_data_i, tx_data;
  logic [7:0]  ft_data_o, rx_data;
  logic        ft_data_oe, ft_oe_n, ft_rd_n, ft_wr_n, ft_siwu_n, rx_valid, tx_ready, busy;
  logic [31:0] rx_cnt, tx_cnt;

  ft_fifo_bus_ctrl #(.MAX_BURST(MB), .SEND_IMM(1'b1)) dut (
    .FT_CLK(FT_CLK), .rst(rst), .enable(enable),
    .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n), .ft_data_i(ft_data_i), .ft_data_o(ft_data_o),
    .ft_data_oe(ft_data_oe), .ft_oe_n(ft_oe_n), .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n),
    .ft_siwu_n(ft_siwu_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_afull(rx_afull),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .rx_cnt(rx_cnt), .tx_cnt(tx_cnt)
  );

  always #5 FT_CLK = ~FT_CLK;

  int n_chk = 0, n_fail = 0;

  // World model state
  logic [7:0] host_q[$];   // bytes the host has queued in the FT chip
  logic [7:0] tx_q[$];     // TX FIFO contents
  logic [7:0] rx_got[$];   // bytes seen on rx_valid
  logic [7:0] ft_got[$];   // bytes accepted by the FT chip from the FPGA
  int         rx_cyc[$];
  bit         log_dir[$];  // 1 = TX burst
  int         log_len[$];
  bit         tx_en = 1'b1;
  int         cyc = 0, siwu_lo = 0, wr_lo = 0, inv_err = 0, gap_err = 0, bad_grant = 0;
  int         afull_rxv = 0, n_starts = 0, idle_run = 0, cur_len = 0;
  int         exp_rx_cnt = 0, exp_tx_cnt = 0;
  bit         prev_oe_n = 1'b1, prev_doe = 1'b0, prev_afull = 1'b0;

  always @(posedge FT_CLK) begin
    bit rdf, wrf, pop;
    rdf = !ft_rd_n && !ft_rxf_n;
    wrf = !ft_wr_n && !ft_txe_n;
    pop = tx_ready;
    cyc++;
    if (rx_valid) begin rx_got.push_back(rx_data); rx_cyc.push_back(cyc); end
    if (!ft_siwu_n) siwu_lo++;
    if (!ft_wr_n) wr_lo++;
    if (ft_data_oe && !ft_oe_n) inv_err++;
    if (rx_afull && rx_valid) afull_rxv++;
    if (!prev_oe_n && ft_oe_n) begin log_dir.push_back(1'b0); log_len.push_back(cur_len); end
    if (prev_doe && !ft_data_oe) begin log_dir.push_back(1'b1); log_len.push_back(cur_len); end
    if (prev_oe_n && !ft_oe_n) begin
      if (idle_run == 0) gap_err++;
      if (prev_afull) bad_grant++;
      n_starts++; cur_len = 0;
    end
    if (!prev_doe && ft_data_oe) begin
      if (idle_run == 0) gap_err++;
      n_starts++; cur_len = 0;
    end
    cur_len += int'(rdf) + int'(pop);
    if (rdf) exp_rx_cnt++;
    if (pop) exp_tx_cnt++;
    if (wrf) ft_got.push_back(ft_data_o);
    idle_run   = busy ? 0 : idle_run + 1;
    prev_oe_n  = ft_oe_n;
    prev_doe   = ft_data_oe;
    prev_afull = rx_afull;
    #1;
    if (rdf && host_q.size() > 0) void'(host_q.pop_front());
    if (pop && tx_q.size() > 0) void'(tx_q.pop_front());
    ft_rxf_n  = (host_q.size() == 0);
    ft_data_i = (host_q.size() > 0) ? host_q[0] : 8'h00;
    tx_valid  = tx_en && (tx_q.size() > 0);
    tx_data   = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
  end

  function automatic int q_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
    int d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) d++;
    return d;
  endfunction

  task automatic clear_logs();
    rx_got.delete(); ft_got.delete(); rx_cyc.delete(); log_dir.delete(); log_len.delete();
    siwu_lo = 0; wr_lo = 0; afull_rxv = 0;
  endtask

  task automatic wait_drain(output int n);
    n = 0;
    while (!(host_q.size() == 0 && tx_q.size() == 0 && !busy) && n < 2000) begin
      @(negedge FT_CLK); n++;
    end
    repeat (4) @(negedge FT_CLK);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; ft_rxf_n = 1'b1; ft_txe_n = 1'b1; rx_afull = 1'b0;
    tx_valid = 1'b0; ft_data_i = 8'h00; tx_data = 8'h00;
    repeat (3) @(negedge FT_CLK);
    n_chk++;
    if ({ft_oe_n, ft_rd_n, ft_wr_n, ft_siwu_n, ft_data_oe, rx_valid, busy, tx_ready} !== 8'b1111_0000) begin
      n_fail++;
      $display("FAIL reset_pins: oe,rd,wr,siwu,doe,rxv,busy,rdy=%b required 11110000",
               {ft_oe_n, ft_rd_n, ft_wr_n, ft_siwu_n, ft_data_oe, rx_valid, busy, tx_ready});
    end
    n_chk++;
    if (rx_cnt !== 32'd0 || tx_cnt !== 32'd0 || rx_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_regs: rx_cnt=%0d tx_cnt=%0d rx_data=%h required 0", rx_cnt, tx_cnt, rx_data);
    end
    rst = 1'b0; enable = 1'b1;
    repeat (2) @(negedge FT_CLK);
    clear_logs();
  endtask

  task automatic test_rx_basic();
    logic [7:0] exp[$];
    int n;
    exp = '{8'hA1, 8'hB2, 8'hC3};
    ft_txe_n = 1'b1;
    foreach (exp[i]) host_q.push_back(exp[i]);
    wait_drain(n);
    n_chk++;
    if (n >= 2000) begin n_fail++; $display("FAIL rx_basic_timeout: waited %0d cycles", n); end
    n_chk++;
    if (q_diff(rx_got, exp) != 0) begin
      n_fail++; $display("FAIL rx_basic_data: got %0d bytes (first %h) required A1,B2,C3", rx_got.size(),
                         rx_got.size() ? rx_got[0] : 8'hxx);
    end
    n_chk++;
    if (rx_cyc.size() != 3 || rx_cyc[2] - rx_cyc[0] != 2) begin
      n_fail++; $display("FAIL rx_basic_consec: %0d rx_valid samples, not 3 back-to-back", rx_cyc.size());
    end
    n_chk++;
    if (rx_cnt !== 32'd3) begin n_fail++; $display("FAIL rx_basic_cnt: rx_cnt=%0d required 3", rx_cnt); end
    n_chk++;
    if (log_len.size() != 1 || log_dir[0] != 1'b0 || log_len[0] != 3) begin
      n_fail++; $display("FAIL rx_basic_burst: %0d bursts logged, required one RX burst of 3", log_len.size());
    end
    clear_logs();
  endtask

  task automatic test_tx_basic();
    logic [7:0] exp[$];
    int n;
    exp = '{8'h00, 8'h01, 8'h02, 8'h03};
    ft_txe_n = 1'b0;
    foreach (exp[i]) tx_q.push_back(exp[i]);
    wait_drain(n);
    n_chk++;
    if (n >= 2000) begin n_fail++; $display("FAIL tx_basic_timeout: waited %0d cycles", n); end
    n_chk++;
    if (q_diff(ft_got, exp) != 0) begin
      n_fail++; $display("FAIL tx_basic_data: FT received %0d bytes, required 00..03", ft_got.size());
    end
    n_chk++;
    if (wr_lo != 4) begin n_fail++; $display("FAIL tx_basic_wr_n: wr_n low %0d cycles required 4", wr_lo); end
    n_chk++;
    if (tx_cnt !== 32'd4) begin n_fail++; $display("FAIL tx_basic_cnt: tx_cnt=%0d required 4", tx_cnt); end
    n_chk++;
    if (siwu_lo != 1) begin n_fail++; $display("FAIL tx_basic_siwu: siwu_n low %0d cycles required 1", siwu_lo); end
    clear_logs();
  endtask

  task automatic test_round_robin();
    logic [7:0] er[$], et[$];
    int n, bad;
    for (int i = 0; i < 3 * MB; i++) begin
      er.push_back(8'($urandom)); et.push_back(8'($urandom));
    end
    ft_txe_n = 1'b0;
    foreach (er[i]) host_q.push_back(er[i]);
    foreach (et[i]) tx_q.push_back(et[i]);
    wait_drain(n);
    n_chk++;
    if (n >= 2000) begin n_fail++; $display("FAIL rr_timeout: waited %0d cycles", n); end
    bad = (log_len.size() == 6) ? 0 : 1;
    for (int i = 0; i < log_len.size(); i++)
      if (log_dir[i] != 1'(i % 2) || log_len[i] != MB) bad++;
    n_chk++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rr_pattern: %0d bursts with %0d deviations, required RX,TX alternating x3 of %0d", log_len.size(), bad, MB);
    end
    n_chk++;
    if (q_diff(rx_got, er) != 0 || q_diff(ft_got, et) != 0) begin
      n_fail++; $display("FAIL rr_data: rx diff=%0d tx diff=%0d required 0", q_diff(rx_got, er), q_diff(ft_got, et));
    end
    n_chk++;
    if (gap_err != 0 || inv_err != 0) begin
      n_fail++; $display("FAIL rr_gap_inv: gap_err=%0d inv_err=%0d required 0", gap_err, inv_err);
    end
    clear_logs();
  endtask

  task automatic test_txe_stall();
    logic [7:0] et[$];
    int n, ntx;
    for (int i = 0; i < 10; i++) et.push_back(8'($urandom));
    ft_txe_n = 1'b0;
    foreach (et[i]) tx_q.push_back(et[i]);
    n = 0;
    while (ft_got.size() < 3 && n < 200) begin @(negedge FT_CLK); n++; end
    n_chk++;
    if (n >= 200) begin n_fail++; $display("FAIL stall_start_timeout: %0d bytes after %0d cycles", ft_got.size(), n); end
    ft_txe_n = 1'b1;
    repeat (3) @(negedge FT_CLK);
    ft_txe_n = 1'b0;
    wait_drain(n);
    ntx = 0;
    foreach (log_dir[i]) if (log_dir[i]) ntx++;
    n_chk++;
    if (q_diff(ft_got, et) != 0) begin
      n_fail++; $display("FAIL stall_data: FT received %0d bytes diff=%0d required 10 in order", ft_got.size(), q_diff(ft_got, et));
    end
    n_chk++;
    if (ntx < 2) begin n_fail++; $display("FAIL stall_regrant: %0d TX bursts required at least 2", ntx); end
    n_chk++;
    if (tx_cnt !== 32'(exp_tx_cnt)) begin n_fail++; $display("FAIL stall_cnt: tx_cnt=%0d required %0d", tx_cnt, exp_tx_cnt); end
    clear_logs();
  endtask

  task automatic test_rx_afull();
    logic [7:0] er[$];
    int n;
    for (int i = 0; i < 20; i++) er.push_back(8'($urandom));
    ft_txe_n = 1'b1;
    foreach (er[i]) host_q.push_back(er[i]);
    n = 0;
    while (rx_got.size() < 2 && n < 200) begin @(negedge FT_CLK); n++; end
    rx_afull = 1'b1; afull_rxv = 0; bad_grant = 0;
    repeat (20) @(negedge FT_CLK);
    n_chk++;
    if (afull_rxv > 2) begin n_fail++; $display("FAIL afull_overrun: %0d rx_valid after afull, required <= 2", afull_rxv); end
    n_chk++;
    if (bad_grant != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL afull_regrant: RX grants while afull=%0d busy=%b required 0/0", bad_grant, busy);
    end
    rx_afull = 1'b0;
    wait_drain(n);
    n_chk++;
    if (q_diff(rx_got, er) != 0) begin n_fail++; $display("FAIL afull_data: rx diff=%0d required 0", q_diff(rx_got, er)); end
    clear_logs();
  endtask

  task automatic test_random();
    logic [7:0] er[$], et[$];
    int n, maxlen;
    gap_err = 0; inv_err = 0; bad_grant = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge FT_CLK);
      if ($urandom_range(0, 2) == 0 && er.size() < 60) begin
        er.push_back(8'($urandom)); host_q.push_back(er[er.size() - 1]);
      end
      if ($urandom_range(0, 2) == 0 && et.size() < 60) begin
        et.push_back(8'($urandom)); tx_q.push_back(et[et.size() - 1]);
      end
      ft_txe_n = ($urandom_range(0, 3) == 0);
      rx_afull = ($urandom_range(0, 7) == 0);
      tx_en    = ($urandom_range(0, 5) != 0);
    end
    @(negedge FT_CLK);
    ft_txe_n = 1'b0; rx_afull = 1'b0; tx_en = 1'b1;
    wait_drain(n);
    maxlen = 0;
    foreach (log_len[i]) if (log_len[i] > maxlen) maxlen = log_len[i];
    n_chk++;
    if (n >= 2000) begin n_fail++; $display("FAIL rand_timeout: waited %0d cycles", n); end
    n_chk++;
    if (q_diff(rx_got, er) != 0) begin n_fail++; $display("FAIL rand_rx_data: diff=%0d got %0d/%0d", q_diff(rx_got, er), rx_got.size(), er.size()); end
    n_chk++;
    if (q_diff(ft_got, et) != 0) begin n_fail++; $display("FAIL rand_tx_data: diff=%0d got %0d/%0d", q_diff(ft_got, et), ft_got.size(), et.size()); end
    n_chk++;
    if (rx_cnt !== 32'(exp_rx_cnt) || tx_cnt !== 32'(exp_tx_cnt)) begin
      n_fail++; $display("FAIL rand_cnt: rx_cnt=%0d tx_cnt=%0d required %0d %0d", rx_cnt, tx_cnt, exp_rx_cnt, exp_tx_cnt);
    end
    n_chk++;
    if (maxlen > MB || gap_err != 0 || inv_err != 0 || bad_grant != 0) begin
      n_fail++; $display("FAIL rand_rules: maxlen=%0d gap=%0d inv=%0d afull_grant=%0d required <=%0d/0/0/0", maxlen, gap_err, inv_err, bad_grant, MB);
    end
    clear_logs();
  endtask

  task automatic test_reset_mid_and_enable();
    logic [7:0] et[$];
    int n, n_pre, st;
    logic [31:0] rc, tc;
    for (int i = 0; i < 12; i++) et.push_back(8'($urandom));
    ft_txe_n = 1'b0;
    foreach (et[i]) tx_q.push_back(et[i]);
    n = 0;
    while (!(ft_data_oe && ft_got.size() >= 2) && n < 200) begin @(negedge FT_CLK); n++; end
    n_chk++;
    if (n >= 200) begin n_fail++; $display("FAIL rst_mid_timeout: TX burst not seen in %0d cycles", n); end
    #2 rst = 1'b1;
    n_pre = ft_got.size(); exp_rx_cnt = 0; exp_tx_cnt = 0;
    #1;
    n_chk++;
    if ({ft_data_oe, ft_wr_n, ft_oe_n, busy} !== 4'b0110) begin
      n_fail++; $display("FAIL rst_mid_pins: doe,wr_n,oe_n,busy=%b required 0110", {ft_data_oe, ft_wr_n, ft_oe_n, busy});
    end
    n_chk++;
    if (rx_cnt !== 32'd0 || tx_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_cnt: rx_cnt=%0d tx_cnt=%0d required 0", rx_cnt, tx_cnt);
    end
    @(negedge FT_CLK); rst = 1'b0;
    wait_drain(n);
    n_chk++;
    if (q_diff(ft_got, et) != 0 || tx_cnt !== 32'(12 - n_pre)) begin
      n_fail++; $display("FAIL rst_resume: FT got %0d diff=%0d tx_cnt=%0d required 12/0/%0d", ft_got.size(), q_diff(ft_got, et), tx_cnt, 12 - n_pre);
    end
    enable = 1'b0;
    st = n_starts; rc = rx_cnt; tc = tx_cnt;
    for (int i = 0; i < 5; i++) begin host_q.push_back(8'($urandom)); tx_q.push_back(8'($urandom)); end
    repeat (20) @(negedge FT_CLK);
    n_chk++;
    if (n_starts != st || busy !== 1'b0 || rx_cnt !== rc || tx_cnt !== tc) begin
      n_fail++; $display("FAIL enable_off: %0d grants busy=%b cnt %0d/%0d required 0 grants, idle, %0d/%0d",
                         n_starts - st, busy, rx_cnt, tx_cnt, rc, tc);
    end
    enable = 1'b1;
    wait_drain(n);
    clear_logs();
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_tx_basic();
    test_round_robin();
    test_txe_stall();
    test_rx_afull();
    test_random();
    test_reset_mid_and_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
